// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and widths for the alu datapath and its sequencer
package alu_pkg;
  localparam int ALU_W = 16;
  localparam int REQ_W = 32;
  typedef enum logic [2:0] {ADD, SUB, AND, OR, NOT, XOR, ROL, ROR} op_e;
  typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational 16-bit ALU; carry is carry-out, borrow, or rotated-out bit
module alu
  import alu_pkg::*;
(
  input  op_e              op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] y,
  output logic             carry,
  output logic             zero
);
  // one pass of the selected operation
  always_comb begin
    {carry, y} = '0;
    case (op)
      ADD: {carry, y} = {1'b0, a} + {1'b0, b};
      SUB: {carry, y} = {1'b0, a} - {1'b0, b};
      AND: y = a & b;
      OR:  y = a | b;
      NOT: y = ~a;
      XOR: y = a ^ b;
      ROL: {carry, y} = {a[ALU_W-1], a[ALU_W-2:0], a[ALU_W-1]};
      ROR: {carry, y} = {a[0], a[0], a[ALU_W-1:1]};
      default: ;
    endcase
  end
  assign zero = y == '0;
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: valid/ready sequencer driving alu in low/high/fix-up passes; ALU_CTRL_WIDE_EN enables 32-bit ops
module alu_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_wide,
  input  logic [REQ_W-1:0] req_a,
  input  logic [REQ_W-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [REQ_W-1:0] resp_out,
  output logic             resp_carry,
  output logic             resp_zero,
  output logic             flag_c,
  output logic             flag_z
);
  state_e state;
  op_e op;
  logic [REQ_W-1:0] a, b;
  logic [ALU_W-1:0] alu_a, alu_b, y;
  logic c, z;
`ifdef ALU_CTRL_WIDE_EN
  logic wide, lo_c, hi_c, arith, wide_c;
  logic [ALU_W-1:0] lo, hi, lo_w, hi_w;
  assign arith = op == ADD || op == SUB;
  // high pass on the upper halves, fix-up pass adds/subtracts 1 from the stored high half
  always_comb begin
    alu_a = state == HI ? a[31:16] : state == FIX ? hi : a[15:0];
    alu_b = state == HI ? b[31:16] : state == FIX ? 16'd1 : b[15:0];
  end
  // stitch the bit that crosses the half boundary into each rotated half
  always_comb begin
    lo_w = op == ROL ? {lo[15:1], a[31]} : op == ROR ? {a[16], lo[14:0]} : lo;
    hi_w = op == ROL ? {y[15:1], a[15]} : op == ROR ? {a[0], y[14:0]} : y;
    wide_c = arith ? c : op == ROL ? a[31] : op == ROR ? a[0] : 1'b0;
  end
`else
  logic unused_hi;
  assign unused_hi = ^{req_wide, a[31:16], b[31:16]};
  assign alu_a = a[15:0];
  assign alu_b = b[15:0];
`endif
  assign req_ready = state == IDLE && !rst;
  alu u_alu (.op(op), .a(alu_a), .b(alu_b), .y(y), .carry(c), .zero(z));
  // sequencing FSM with registered response and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_out <= '0;
      resp_carry <= 1'b0;
      resp_zero <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a <= req_a;
          b <= req_b;
          op <= op_e'(req_op);
`ifdef ALU_CTRL_WIDE_EN
          wide <= req_wide;
`endif
          state <= LO;
        end
        LO:
`ifdef ALU_CTRL_WIDE_EN
          if (wide) begin
            lo <= y;
            lo_c <= c;
            state <= HI;
          end else
`endif
          begin
            resp_out <= {16'h0, y};
            resp_carry <= c;
            resp_zero <= z;
            resp_valid <= 1'b1;
            state <= RESP;
          end
`ifdef ALU_CTRL_WIDE_EN
        HI: if (arith && lo_c) begin
          hi <= y;
          hi_c <= c;
          state <= FIX;
        end else begin
          resp_out <= {hi_w, lo_w};
          resp_carry <= wide_c;
          resp_zero <= {hi_w, lo_w} == '0;
          resp_valid <= 1'b1;
          state <= RESP;
        end
        FIX: begin
          resp_out <= {y, lo};
          resp_carry <= hi_c | c;
          resp_zero <= {y, lo} == '0;
          resp_valid <= 1'b1;
          state <= RESP;
        end
`endif
        RESP: if (resp_ready) begin
          flag_c <= resp_carry;
          flag_z <= resp_zero;
          resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: scoreboard bench for alu_ctrl covering narrow/wide ops, latency, hold and mid-op reset
module tb_alu_ctrl;
`ifdef ALU_CTRL_WIDE_EN
  localparam bit WIDE = 1'b1;
`else
  localparam bit WIDE = 1'b0;
`endif
  typedef struct {
    logic [31:0] out;
    logic        c;
    logic        z;
    int          lat;
  } exp_t;
  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic clk = 1'b0, rst, req_valid, req_ready, req_wide, resp_valid, resp_ready;
  logic resp_carry, resp_zero, flag_c, flag_z;
  logic [2:0] req_op;
  logic [31:0] req_a, req_b, resp_out;
  exp_t sb[$];
  int passed = 0, total = 0;
  logic fc = 1'b0, fz = 1'b0;

  alu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_wide(req_wide), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
    .resp_carry(resp_carry), .resp_zero(resp_zero), .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(logic [2:0] op, logic w, logic [31:0] a, logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    logic [16:0] t;
    logic [15:0] a16, b16;
    a16 = a[15:0];
    b16 = b[15:0];
    e.c = 1'b0;
    if (w && WIDE) begin
      case (op)
        3'd0: begin s = {1'b0, a} + {1'b0, b}; e.out = s[31:0]; e.c = s[32]; end
        3'd1: begin s = {1'b0, a} - {1'b0, b}; e.out = s[31:0]; e.c = s[32]; end
        3'd2: e.out = a & b;
        3'd3: e.out = a | b;
        3'd4: e.out = ~a;
        3'd5: e.out = a ^ b;
        3'd6: begin e.out = {a[30:0], a[31]}; e.c = a[31]; end
        default: begin e.out = {a[0], a[31:1]}; e.c = a[0]; end
      endcase
      t = op == 3'd0 ? {1'b0, a16} + {1'b0, b16} : {1'b0, a16} - {1'b0, b16};
      e.lat = (op <= 3'd1 && t[16]) ? 4 : 3;
    end else begin
      case (op)
        3'd0: t = {1'b0, a16} + {1'b0, b16};
        3'd1: t = {1'b0, a16} - {1'b0, b16};
        3'd2: t = {1'b0, a16 & b16};
        3'd3: t = {1'b0, a16 | b16};
        3'd4: t = {1'b0, ~a16};
        3'd5: t = {1'b0, a16 ^ b16};
        3'd6: t = {a16[15], a16[14:0], a16[15]};
        default: t = {a16[0], a16[0], a16[15:1]};
      endcase
      e.out = {16'h0, t[15:0]};
      e.c = t[16];
      e.lat = 2;
    end
    e.z = e.out == 32'h0;
    return e;
  endfunction

  task automatic send(input logic [2:0] op, input logic w, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(op, w, a, b));
    req_op = op;
    req_wide = w;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic handshake;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else passed++;
    total++; if (resp_out !== 32'h0) $display("FAIL reset_resp_out got %h want 0", resp_out); else passed++;
    total++; if ({flag_c, flag_z} !== 2'b00) $display("FAIL reset_flags got %b want 00", {flag_c, flag_z}); else passed++;
    total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready_in_rst got %b want 0", req_ready); else passed++;
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready_after got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_ops;
    req_t dir [10];
    req_t r;
    exp_t e;
    int n;
    dir = '{
      '{3'd0, 1'b0, 32'h0000FFFF, 32'h00000001},
      '{3'd0, 1'b1, 32'h0000FFFF, 32'h00000001},
      '{3'd1, 1'b1, 32'h00010000, 32'h00000001},
      '{3'd1, 1'b1, 32'h00000000, 32'h00000001},
      '{3'd6, 1'b1, 32'h80008000, 32'h00000000},
      '{3'd7, 1'b1, 32'h00000001, 32'h00000000},
      '{3'd5, 1'b0, 32'h000000FF, 32'h00000F0F},
      '{3'd1, 1'b0, 32'h00000000, 32'h00000001},
      '{3'd2, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F},
      '{3'd4, 1'b1, 32'h1234ABCD, 32'h00000000}
    };
    for (int i = 0; i < 40; i++) begin
      if (i < 10) r = dir[i];
      else begin
        r.op = 3'($urandom_range(0, 7));
        r.w = 1'($urandom_range(0, 1));
        r.a = $urandom;
        r.b = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      end
      total++; if (req_ready !== 1'b1) $display("FAIL op%0d_req_ready_idle got %b want 1", i, req_ready); else passed++;
      send(r.op, r.w, r.a, r.b);
      wait_resp(n);
      e = sb.pop_front();
      total++; if (n + 1 !== e.lat) $display("FAIL op%0d_latency got %0d want %0d", i, n + 1, e.lat); else passed++;
      total++; if (resp_out !== e.out) $display("FAIL op%0d_out got %h want %h", i, resp_out, e.out); else passed++;
      total++; if (resp_carry !== e.c) $display("FAIL op%0d_carry got %b want %b", i, resp_carry, e.c); else passed++;
      total++; if (resp_zero !== e.z) $display("FAIL op%0d_zero got %b want %b", i, resp_zero, e.z); else passed++;
      total++; if (req_ready !== 1'b0) $display("FAIL op%0d_req_ready_busy got %b want 0", i, req_ready); else passed++;
      handshake();
      fc = e.c;
      fz = e.z;
      total++; if ({flag_c, flag_z} !== {fc, fz}) $display("FAIL op%0d_flags got %b want %b", i, {flag_c, flag_z}, {fc, fz}); else passed++;
      total++; if (resp_valid !== 1'b0) $display("FAIL op%0d_resp_valid_drop got %b want 0", i, resp_valid); else passed++;
    end
  endtask

  task automatic test_hold;
    exp_t e;
    int n;
    send(3'd3, 1'b0, 32'h1, 32'h0);
    wait_resp(n);
    e = sb.pop_front();
    total++; if (resp_out !== e.out) $display("FAIL hold_pre_out got %h want %h", resp_out, e.out); else passed++;
    handshake();
    fc = e.c;
    fz = e.z;
    send(3'd0, 1'b0, 32'h0000FFFF, 32'h1);
    wait_resp(n);
    e = sb.pop_front();
    total++; if (resp_valid !== 1'b1) $display("FAIL hold_resp_valid got %b want 1", resp_valid); else passed++;
    for (int k = 0; k < 5; k++) begin
      total++; if ({resp_valid, resp_out, resp_carry, resp_zero} !== {1'b1, e.out, e.c, e.z})
        $display("FAIL hold%0d_outputs got %b/%h/%b/%b want 1/%h/%b/%b", k, resp_valid, resp_out, resp_carry, resp_zero, e.out, e.c, e.z);
      else passed++;
      total++; if (req_ready !== 1'b0) $display("FAIL hold%0d_req_ready got %b want 0", k, req_ready); else passed++;
      total++; if ({flag_c, flag_z} !== {fc, fz}) $display("FAIL hold%0d_flags got %b want %b", k, {flag_c, flag_z}, {fc, fz}); else passed++;
      @(posedge clk);
      #1;
    end
    handshake();
    fc = e.c;
    fz = e.z;
    total++; if ({flag_c, flag_z} !== 2'b11) $display("FAIL hold_flags_after got %b want 11", {flag_c, flag_z}); else passed++;
  endtask

  task automatic test_rst_mid;
    exp_t e;
    int n;
    send(3'd0, 1'b1, 32'h0000FFFF, 32'h1);
    if (WIDE) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    e = sb.pop_back();
    total++; if (resp_valid !== 1'b0) $display("FAIL rstmid_resp_valid got %b want 0", resp_valid); else passed++;
    total++; if ({flag_c, flag_z} !== 2'b00) $display("FAIL rstmid_flags got %b want 00", {flag_c, flag_z}); else passed++;
    total++; if (resp_out !== 32'h0) $display("FAIL rstmid_out got %h want 0", resp_out); else passed++;
    total++; if (req_ready !== 1'b0) $display("FAIL rstmid_req_ready_in_rst got %b want 0", req_ready); else passed++;
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL rstmid_req_ready_after got %b want 1", req_ready); else passed++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      total++; if (resp_valid !== 1'b0) $display("FAIL rstmid_dropped%0d got %b want 0", k, resp_valid); else passed++;
    end
    send(3'd5, 1'b0, 32'h000000FF, 32'h00000F0F);
    wait_resp(n);
    e = sb.pop_front();
    total++; if (n + 1 !== 2) $display("FAIL rstmid_xor_latency got %0d want 2", n + 1); else passed++;
    total++; if (resp_out !== 32'h00000FF0) $display("FAIL rstmid_xor_out got %h want 00000ff0", resp_out); else passed++;
    total++; if (resp_out !== e.out) $display("FAIL rstmid_xor_model got %h want %h", resp_out, e.out); else passed++;
    handshake();
    total++; if ({flag_c, flag_z} !== 2'b00) $display("FAIL rstmid_xor_flags got %b want 00", {flag_c, flag_z}); else passed++;
  endtask

  initial begin
    req_valid = 1'b0;
    req_op = 3'd0;
    req_wide = 1'b0;
    req_a = 32'h0;
    req_b = 32'h0;
    resp_ready = 1'b0;
    test_reset();
    test_ops();
    test_hold();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
